// File: rtl/memtest_defs.sv
// Shared definitions for the Wishbone memory tester: FSM states,
// pattern mode codes and Galois LFSR tap masks per data width.
package memtest_defs;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_ADDR = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    // Maximal-length Galois masks (right-shifting form), bit n-1 = x^n term.
    function automatic logic [63:0] lfsr_taps(input int dw);
        logic [63:0] t;
        case (dw)
            16:      t = 64'h0000_0000_0000_B400;
            24:      t = 64'h0000_0000_00E1_0000;
            32:      t = 64'h0000_0000_8020_0003;
            40:      t = 64'h0000_00A0_0014_0000;
            48:      t = 64'h0000_C000_0018_0000;
            56:      t = 64'h00C0_0006_0000_0000;
            64:      t = 64'hD800_0000_0000_0000;
            default: t = 64'h0000_0000_0000_0001;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/memtest_pattern.sv
// Expected-data generator: address, inverted address, or Galois LFSR.
// The LFSR mode exists only when WB_MEMTEST_LFSR_EN is defined.
module memtest_pattern
    import memtest_defs::*;
#(
    parameter int AW = 19,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [1:0]    i_mode,
    input  logic [AW-1:0] i_addr,
    input  logic          i_advance,
    input  logic          i_reseed,
    output logic [DW-1:0] o_expected
);

    logic [DW-1:0] w_base;

    if (DW > AW) begin : g_ext
        assign w_base = {{(DW-AW){1'b0}}, i_addr};
    end else if (DW == AW) begin : g_same
        assign w_base = i_addr;
    end else begin : g_trunc
        assign w_base = i_addr[DW-1:0];
    end

`ifdef WB_MEMTEST_LFSR_EN
    localparam logic [63:0] TAPS64 = lfsr_taps(DW);
    localparam logic [DW-1:0] TAPS = TAPS64[DW-1:0];
    localparam logic [DW-1:0] SEED = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] r_lfsr;

    // Reseed wins over advance so the last write ack restarts the sequence.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lfsr <= SEED;
        end else if (i_reseed) begin
            r_lfsr <= SEED;
        end else if (i_advance) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    always_comb begin
        o_expected = w_base;
        case (i_mode)
            MODE_INV:  o_expected = ~w_base;
            MODE_LFSR: o_expected = r_lfsr;
            default:   o_expected = w_base;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, i_clk, i_reset_n, i_advance, i_reseed};

    always_comb begin
        o_expected = w_base;
        case (i_mode)
            MODE_INV: o_expected = ~w_base;
            default:  o_expected = w_base;
        endcase
    end
`endif

endmodule

// File: rtl/wb_memtest.sv
// Wishbone memory tester: writes a pattern to every word, reads it back.
// Define WB_MEMTEST_LFSR_EN to build the LFSR pattern mode.
module wb_memtest
    import memtest_defs::*;
#(
    parameter int AW      = 19,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [1:0]      i_mode,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_stall,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [15:0]     o_err_count,
    output logic [AW-1:0]   o_first_err_addr,
    output logic [DW-1:0]   o_first_err_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    logic          r_cyc;
    logic          r_stb;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [1:0]    r_mode;
    logic [TW-1:0] r_tmo;
    logic          r_pass;
    logic          r_seen;
    logic [15:0]   r_err_count;
    logic [AW-1:0] r_first_addr;
    logic [DW-1:0] r_first_data;

    logic          w_start;
    logic          w_ack;
    logic          w_last;
    logic          w_mis;
    logic          w_reseed;
    logic [DW-1:0] w_pat;

    assign o_busy           = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign o_done           = (r_state == ST_DONE);
    assign o_pass           = r_pass;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_addr;
    assign o_first_err_data = r_first_data;
    assign o_wb_cyc         = r_cyc;
    assign o_wb_stb         = r_stb;
    assign o_wb_we          = r_we;
    assign o_wb_addr        = r_addr;
    assign o_wb_data        = r_data;
    assign o_wb_sel         = '1;

    assign w_start  = i_start && !o_busy;
    assign w_ack    = r_cyc && i_wb_ack && !i_wb_err;
    assign w_last   = &r_addr;
    assign w_mis    = (i_wb_data != w_pat);
    assign w_reseed = w_start || (w_ack && w_last && (r_state == ST_WRITE));

    memtest_pattern #(.AW(AW), .DW(DW)) u_pattern (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_mode     (r_mode),
        .i_addr     (r_addr),
        .i_advance  (w_ack),
        .i_reseed   (w_reseed),
        .o_expected (w_pat)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_mode       <= MODE_ADDR;
            r_tmo        <= '0;
            r_pass       <= 1'b0;
            r_seen       <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state      <= ST_WRITE;
                        r_addr       <= '0;
                        r_pass       <= 1'b0;
                        r_seen       <= 1'b0;
                        r_err_count  <= '0;
                        r_first_addr <= '0;
                        r_first_data <= '0;
                        if (i_mode == MODE_INV || i_mode == MODE_LFSR)
                            r_mode <= i_mode;
                        else
                            r_mode <= MODE_ADDR;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (!r_cyc) begin
                        r_cyc  <= 1'b1;
                        r_stb  <= 1'b1;
                        r_we   <= (r_state == ST_WRITE);
                        r_data <= (r_state == ST_WRITE) ? w_pat : '0;
                        r_tmo  <= '0;
                    end else begin
                        if (r_stb && !i_wb_stall)
                            r_stb <= 1'b0;
                        if (i_wb_err) begin
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_state <= ST_DONE;
                            r_pass  <= 1'b0;
                            if (r_err_count != 16'hFFFF)
                                r_err_count <= r_err_count + 16'd1;
                        end else if (i_wb_ack) begin
                            r_cyc  <= 1'b0;
                            r_stb  <= 1'b0;
                            r_we   <= 1'b0;
                            r_addr <= r_addr + AW'(1);
                            if (r_state == ST_WRITE) begin
                                if (w_last)
                                    r_state <= ST_READ;
                            end else begin
                                if (w_mis) begin
                                    if (r_err_count != 16'hFFFF)
                                        r_err_count <= r_err_count + 16'd1;
                                    if (!r_seen) begin
                                        r_seen       <= 1'b1;
                                        r_first_addr <= r_addr;
                                        r_first_data <= i_wb_data;
                                    end
                                end
                                if (w_last) begin
                                    r_state <= ST_DONE;
                                    r_pass  <= (r_err_count == 16'd0) && !w_mis;
                                end
                            end
                        end else if (r_tmo == TW'(TIMEOUT)) begin
                            // Stuck slave: give up on this request.
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_state <= ST_DONE;
                            r_pass  <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_memtest.sv
// Scoreboard bench for wb_memtest (AW=4, DW=32, TIMEOUT=15) with a
// configurable Wishbone slave model.
module tb_wb_memtest;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int TMO = 15;

`ifdef WB_MEMTEST_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode  = 2'd0;
    logic            ack   = 1'b0;
    logic            stall = 1'b0;
    logic            err   = 1'b0;
    logic [DW-1:0]   rdata = '0;
    logic            cyc, stb, we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] sel;
    logic            busy, done, pass;
    logic [15:0]     ecnt;
    logic [AW-1:0]   faddr;
    logic [DW-1:0]   fdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_memtest #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_start          (start),
        .i_mode           (mode),
        .o_wb_cyc         (cyc),
        .o_wb_stb         (stb),
        .o_wb_we          (we),
        .o_wb_addr        (addr),
        .o_wb_data        (wdata),
        .o_wb_sel         (sel),
        .i_wb_ack         (ack),
        .i_wb_stall       (stall),
        .i_wb_err         (err),
        .i_wb_data        (rdata),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass           (pass),
        .o_err_count      (ecnt),
        .o_first_err_addr (faddr),
        .o_first_err_data (fdata)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct {
        logic          p;
        logic [15:0]   c;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } st_t;

    req_t rq[$];
    st_t  sq[$];

    // slave knobs (written by stimulus only)
    bit stall_en  = 1'b0;
    bit late_ack  = 1'b0;
    int max_dly   = 0;
    int fixed_dly = -1;
    int stuck_a   = -1;
    int stuck_b   = 0;
    int noack_a   = -1;
    int err_a     = -1;

    // slave state (written by slave only)
    logic [DW-1:0] mem [16];
    bit            s_busy  = 1'b0;
    int            s_cnt   = 0;
    logic          s_we    = 1'b0;
    logic [AW-1:0] s_a     = '0;
    logic [DW-1:0] s_d     = '0;
    int            ack_cnt = 0;

    always @(negedge clk) begin
        ack   = 1'b0;
        err   = 1'b0;
        stall = 1'b0;
        if (!rst_n && !late_ack)
            s_busy = 1'b0;
        if (rst_n && !s_busy && cyc && stb) begin
            if (stall_en && $urandom_range(0, 1) == 1) begin
                stall = 1'b1;
            end else begin
                s_busy = 1'b1;
                s_we   = we;
                s_a    = addr;
                s_d    = wdata;
                s_cnt  = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, max_dly);
            end
        end
        if (s_busy) begin
            if (s_cnt > 0) begin
                s_cnt--;
            end else if (!(s_we && noack_a == int'(s_a))) begin
                s_busy = 1'b0;
                if (!s_we && err_a == int'(s_a)) begin
                    err = 1'b1;
                end else begin
                    ack = 1'b1;
                    ack_cnt++;
                    if (s_we) begin
                        mem[s_a] = s_d;
                    end else begin
                        rdata = mem[s_a];
                        if (stuck_a == int'(s_a))
                            rdata[stuck_b] = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: pops expected requests / final status as the DUT presents them
    logic          p_st   = 1'b0;
    logic          p_done = 1'b0;
    logic          p_we;
    logic [AW-1:0] p_a;
    logic [DW-1:0] p_d;
    int            run      = 0;
    int            last_len = 0;
    req_t          m_r;
    st_t           m_s;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            p_st   = 1'b0;
            p_done = 1'b0;
            run    = 0;
        end else begin
            if (cyc && stb) begin
                if (p_st) begin
                    checks++;
                    if ({we, addr, wdata} !== {p_we, p_a, p_d}) begin
                        errors++;
                        $display("FAIL stall_hold got %b/%0d/%h want %b/%0d/%h",
                                 we, addr, wdata, p_we, p_a, p_d);
                    end
                end
                if (!stall) begin
                    checks++;
                    if (rq.size() == 0) begin
                        errors++;
                        $display("FAIL req_extra got we=%b addr=%0d want none", we, addr);
                    end else begin
                        m_r = rq.pop_front();
                        if (we !== m_r.we || addr !== m_r.a || sel !== {(DW/8){1'b1}} ||
                            (m_r.we && wdata !== m_r.d)) begin
                            errors++;
                            $display("FAIL req got we=%b addr=%0d data=%h sel=%h want we=%b addr=%0d data=%h",
                                     we, addr, wdata, sel, m_r.we, m_r.a, m_r.d);
                        end
                    end
                end
            end
            p_st = cyc && stb && stall;
            p_we = we;
            p_a  = addr;
            p_d  = wdata;
            if (cyc) begin
                run++;
            end else if (run > 0) begin
                last_len = run;
                run      = 0;
            end
            if (done && !p_done) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL status_extra got done=1 want none");
                end else begin
                    m_s = sq.pop_front();
                    if (pass !== m_s.p || ecnt !== m_s.c || faddr !== m_s.fa ||
                        fdata !== m_s.fd || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL status got pass=%b cnt=%0d fa=%0d fd=%h busy=%b want pass=%b cnt=%0d fa=%0d fd=%h busy=0",
                                 pass, ecnt, faddr, fdata, busy, m_s.p, m_s.c, m_s.fa, m_s.fd);
                    end
                end
            end
            p_done = done;
        end
    end

    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic expect_run(input int m, input int nw, input int nr, input logic p,
                              input logic [15:0] c, input logic [AW-1:0] fa,
                              input logic [DW-1:0] fd);
        req_t          r;
        st_t           s;
        logic [DW-1:0] l;
        l = 1;
        rq.delete();
        sq.delete();
        for (int i = 0; i < nw; i++) begin
            r.we = 1'b1;
            r.a  = AW'(i);
            if (m == 1)
                r.d = ~DW'(i);
            else if (m == 2 && LFSR_ON)
                r.d = l;
            else
                r.d = DW'(i);
            rq.push_back(r);
            l = lfsr_next(l);
        end
        for (int i = 0; i < nr; i++) begin
            r.we = 1'b0;
            r.a  = AW'(i);
            r.d  = '0;
            rq.push_back(r);
        end
        s = '{p, c, fa, fd};
        sq.push_back(s);
    endtask

    task automatic go(input logic [1:0] m);
        @(negedge clk);
        #2;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        mode  = 2'd3;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        #2;
        while (!done && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done got 0 want 1", nm);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    initial begin
        int a0;
        int n;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_bus", 64'({cyc, stb, we, addr, wdata}), 64'd0);
        chk("rst_stat", 64'({busy, done, pass, ecnt, faddr, fdata}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_bus", 64'({cyc, busy, done}), 64'd0);

        // mode 0, zero-stall slave
        expect_run(0, 16, 16, 1'b1, 16'd0, '0, '0);
        a0 = ack_cnt;
        go(2'd0);
        wait_done("m0");
        chk("m0_acks", 64'(ack_cnt - a0), 64'd32);
        chk("m0_q", 64'(rq.size()), 64'd0);

        // mode 1, bit 3 of address 5 stuck low on read
        stuck_a = 5;
        stuck_b = 3;
        expect_run(1, 16, 16, 1'b0, 16'd1, AW'(5), 32'hFFFF_FFF2);
        go(2'd1);
        wait_done("m1");
        chk("m1_q", 64'(rq.size()), 64'd0);
        stuck_a = -1;

        // random stall and ack delay; a start pulse mid-run must be ignored
        stall_en = 1'b1;
        max_dly  = 5;
        expect_run(0, 16, 16, 1'b1, 16'd0, '0, '0);
        a0 = ack_cnt;
        go(2'd0);
        repeat (20) @(negedge clk);
        #2;
        start = 1'b1;
        mode  = 2'd1;
        @(negedge clk);
        #2;
        start = 1'b0;
        wait_done("stall");
        chk("stall_acks", 64'(ack_cnt - a0), 64'd32);
        chk("stall_q", 64'(rq.size()), 64'd0);
        stall_en = 1'b0;
        max_dly  = 0;

        // address 7 never acked during WRITE
        noack_a = 7;
        expect_run(0, 8, 0, 1'b0, 16'd0, '0, '0);
        go(2'd0);
        wait_done("tmo");
        chk("tmo_cyc_len", 64'(last_len), 64'd16);
        chk("tmo_q", 64'(rq.size()), 64'd0);
        chk("tmo_cyc", 64'(cyc), 64'd0);
        noack_a = -1;
        rst_n   = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // bus error on read of address 2
        err_a = 2;
        expect_run(0, 16, 3, 1'b0, 16'd1, '0, '0);
        go(2'd0);
        wait_done("err");
        chk("err_q", 64'(rq.size()), 64'd0);
        err_a = -1;

        // LFSR mode (address pattern when the feature is not built)
        expect_run(2, 16, 16, 1'b1, 16'd0, '0, '0);
        go(2'd2);
        wait_done("m2");
        chk("m2_q", 64'(rq.size()), 64'd0);

        // mode 3 behaves as mode 0
        expect_run(3, 16, 16, 1'b1, 16'd0, '0, '0);
        go(2'd3);
        wait_done("m3");
        chk("m3_q", 64'(rq.size()), 64'd0);

        // reset while a read is outstanding; the late ack lands in IDLE
        fixed_dly = 4;
        late_ack  = 1'b1;
        expect_run(0, 16, 16, 1'b1, 16'd0, '0, '0);
        go(2'd0);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(s_busy && !s_we) && n < 2000);
        chk("rd_reached", 64'(s_busy && !s_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus", 64'({cyc, stb, we, addr, wdata}), 64'd0);
        chk("rst_mid_stat", 64'({busy, done, pass, ecnt, faddr, fdata}), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk("late_ack_idle", 64'({cyc, stb, busy, done, ecnt}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
